// File: rtl/array_mult_reg_pkg.sv
// Shared constants and helpers for the array multiplier leaf.
package array_mult_reg_pkg;

    // Widest operand the array generator is expected to build.
    localparam int MULT_MAX_WIDTH = 16;

    // Product width needed to hold the full unsigned product.
    function automatic int mult_prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/array_mult_reg_full_adder_cell.sv
// One-bit full adder; doubles as a half adder when cin is tied low.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/array_mult_reg.sv
// Unsigned WIDTH x WIDTH carry-save array multiplier with a registered
// product and valid flag (one cycle latency, one op per cycle).
module array_mult_reg
    import array_mult_reg_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 out_valid
);

    localparam int PW = mult_prod_width(WIDTH);

    if (WIDTH < 1 || WIDTH > MULT_MAX_WIDTH) begin : g_bad_width
        $error("array_mult_reg: WIDTH out of range");
    end

    logic [PW-1:0] prod;

    if (WIDTH == 1) begin : g_w1
        assign prod = {1'b0, A[0] & B[0]};
    end else begin : g_array
        // Row i holds the carry-save (sum, carry) pair after folding in
        // partial-product row i. Sum bit j of row i has weight i+j, carry
        // bit j has weight i+j+1, so the LSB of each row is final.
        for (genvar i = 0; i < WIDTH; i++) begin : g_row
            logic [WIDTH-1:0] s;
            logic [WIDTH-1:0] c;

            if (i == 0) begin : g_first
                for (genvar j = 0; j < WIDTH; j++) begin : g_pp
                    assign s[j] = A[j] & B[0];
                end
                assign c = '0;
            end else begin : g_add
                for (genvar j = 0; j < WIDTH; j++) begin : g_cell
                    logic bi;
                    // Previous row's sum shifted down one place; nothing
                    // sits above its top bit.
                    if (j == WIDTH - 1) begin : g_top
                        assign bi = 1'b0;
                    end else begin : g_mid
                        assign bi = g_row[i-1].s[j+1];
                    end
                    full_adder_cell u_fa (
                        .a    (A[j] & B[i]),
                        .b    (bi),
                        .cin  (g_row[i-1].c[j]),
                        .s    (s[j]),
                        .cout (c[j])
                    );
                end
            end

            assign prod[i] = s[0];
        end

        // Final ripple row merges the last sum/carry vectors into the upper
        // half of the product.
        for (genvar k = 0; k < WIDTH - 1; k++) begin : g_rpl
            logic ci;
            logic co;
            if (k == 0) begin : g_c0
                assign ci = 1'b0;
            end else begin : g_cn
                assign ci = g_rpl[k-1].co;
            end
            full_adder_cell u_fa (
                .a    (g_row[WIDTH-1].s[k+1]),
                .b    (g_row[WIDTH-1].c[k]),
                .cin  (ci),
                .s    (prod[WIDTH+k]),
                .cout (co)
            );
        end

        // Top bit: the product always fits in PW bits, so this position
        // can never carry out and a plain XOR completes the ripple.
        assign prod[PW-1] = g_row[WIDTH-1].c[WIDTH-1] ^ g_rpl[WIDTH-2].co;
    end

    logic [PW-1:0] p_q, p_d;
    logic          vld_q, vld_d;

    // Next state: capture on in_valid, otherwise hold P and drop valid.
    always_comb begin
        p_d   = p_q;
        vld_d = 1'b0;
        if (in_valid) begin
            p_d   = prod;
            vld_d = 1'b1;
        end
    end

    // Output registers; reset wins over a simultaneous in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            vld_q <= vld_d;
        end
    end

    assign P         = p_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_array_mult_reg.sv
// Randomized + directed bench for array_mult_reg at WIDTH=2 and WIDTH=8,
// checked against a plain-arithmetic reference model.
module tb_array_mult_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv2, iv8;
    logic [1:0]  a2, b2;
    logic [7:0]  a8, b8;
    logic [3:0]  p2;
    logic [15:0] p8;
    logic        ov2, ov8;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int  m2p, m8p;
    bit  m2v, m8v;

    always #5 clk = ~clk;

    array_mult_reg #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .A(a2), .B(b2),
        .P(p2), .out_valid(ov2)
    );

    array_mult_reg #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .A(a8), .B(b8),
        .P(p8), .out_valid(ov8)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare both DUTs shortly after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            m2p = 0; m2v = 0; m8p = 0; m8v = 0;
        end else begin
            if (iv2) begin m2p = int'(a2) * int'(b2); m2v = 1; end else m2v = 0;
            if (iv8) begin m8p = int'(a8) * int'(b8); m8v = 1; end else m8v = 0;
        end
        #1;
        chk({tag, ".p2"}, $isunknown(p2) ? -1 : int'(p2), m2p);
        chk({tag, ".v2"}, int'(ov2), int'(m2v));
        chk({tag, ".p8"}, $isunknown(p8) ? -1 : int'(p8), m8p);
        chk({tag, ".v8"}, int'(ov8), int'(m8v));
    endtask

    task automatic drv2(input bit v, input int a, input int b);
        iv2 = v; a2 = 2'(a); b2 = 2'(b);
    endtask

    task automatic drv8(input bit v, input int a, input int b);
        iv8 = v; a8 = 8'(a); b8 = 8'(b);
    endtask

    int dir_a [9] = '{2, 3, 3, 1, 2, 3, 1, 2, 1};
    int dir_b [9] = '{2, 1, 3, 3, 1, 2, 1, 3, 2};
    int dir_p [9] = '{4, 3, 9, 3, 2, 6, 1, 6, 2};
    int c8_a  [3] = '{255, 255, 128};
    int c8_b  [3] = '{255, 1, 2};
    int c8_p  [3] = '{65025, 255, 256};

    initial begin
        m2p = 0; m8p = 0; m2v = 0; m8v = 0;
        rst = 1'b1;
        drv2(1, 3, 3);
        drv8(1, 255, 255);

        // Reset held with in_valid high: outputs stay cleared
        step("rst0");
        step("rst1");
        chk("rst.p2_zero", int'(p2), 0);

        rst = 1'b0;
        step("rst_rel");
        chk("rst_rel.p2_nine", int'(p2), 9);
        chk("rst_rel.p8_max", int'(p8), 65025);

        // Directed back-to-back sequence with literal expectations
        for (int i = 0; i < 9; i++) begin
            drv2(1, dir_a[i], dir_b[i]);
            drv8(1, dir_a[i], dir_b[i]);
            step("dir");
            chk("dir.lit", int'(p2), dir_p[i]);
            chk("dir.vld", int'(ov2), 1);
        end

        // Exhaustive WIDTH=2, zeros included
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                drv2(1, a, b);
                drv8(1, a * 60 + 15, b * 60 + 15);
                step("exh");
            end
        end
        drv2(1, 0, 3); step("zero_a"); chk("zero_a.lit", int'(p2), 0);
        drv2(1, 3, 0); step("zero_b"); chk("zero_b.lit", int'(p2), 0);

        // Hold: in_valid low keeps P, drops out_valid
        drv2(1, 3, 2); drv8(1, 200, 3); step("hold_ld");
        drv2(0, 1, 1); drv8(0, 1, 1);   step("hold");
        chk("hold.p2_six", int'(p2), 6);
        chk("hold.v2_low", int'(ov2), 0);
        step("hold2");

        // Mid-stream reset beats in_valid
        drv2(1, 2, 3); drv8(1, 77, 91); rst = 1'b1;
        step("mid_rst");
        chk("mid_rst.p2_zero", int'(p2), 0);
        rst = 1'b0;
        step("mid_rel");
        chk("mid_rel.p2_six", int'(p2), 6);

        // WIDTH=8 corners with literal expectations
        for (int i = 0; i < 3; i++) begin
            drv8(1, c8_a[i], c8_b[i]);
            drv2(1, c8_a[i] & 3, c8_b[i] & 3);
            step("c8");
            chk("c8.lit", int'(p8), c8_p[i]);
        end

        // Random pairs with randomly gapped valids
        for (int i = 0; i < 1000; i++) begin
            drv8(($urandom_range(0, 7) != 0), $urandom_range(0, 255), $urandom_range(0, 255));
            drv2(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3));
            rst = ($urandom_range(0, 99) == 0);
            step("rnd");
        end
        rst = 1'b0;
        drv2(0, 0, 0); drv8(0, 0, 0);
        step("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/array_mult_reg.md
Name: array_mult_reg

Overview:
- Unsigned integer multiplier: P = A * B, built as a structural carry-save/ripple array of partial products.
- Product is registered, with a valid flag alongside it.
- Used as a generated datapath leaf in multiplier design-space exploration.
- Default configuration is 2-bit x 2-bit; scales by parameter to 8-bit and beyond.

Parameters:
- WIDTH, 2, operand width in bits for A and B (legal range 1..16).
- PW, 2*WIDTH, product width (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  A/B are sampled this cycle.
- A  input  WIDTH  unsigned multiplicand.
- B  input  WIDTH  unsigned multiplier.
- P  output  PW  registered unsigned product.
- out_valid  output  1  P holds the product of the operands sampled on the previous cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Arithmetic:
  - Fully unsigned.
  - P = A * B exactly, with no truncation: PW bits always hold the full product.
  - Maximum value is (2^WIDTH - 1)^2; for WIDTH=2 that is 9.
- Datapath:
  - Partial products pp[i][j] = A[j] & B[i].
  - Rows are reduced by an array of full/half-adder cells.
  - The final row is a ripple-carry adder.
  - Entirely combinational up to the output register.
  - The "*" operator is not used.
- Latency: exactly 1 cycle.
  - On the rising edge where in_valid=1, P <= A*B and out_valid <= 1.
  - On the rising edge where in_valid=0, P holds its previous value and out_valid <= 0.
- Throughput: one operation per cycle; back-to-back in_valid is fully supported.
- Reset:
  - When rst=1 at a rising edge, P <= 0 and out_valid <= 0, regardless of in_valid.
  - Reset takes priority over a simultaneous in_valid.
  - An operation in flight when reset asserts is discarded.
  - The first edge after rst deasserts behaves normally.
- Zero operands: if either operand is 0, P = 0.
- Identity: if A = 1, P = B zero-extended to PW bits.
- Repeated identical inputs yield identical outputs; there is no internal state besides the output registers.
- No X propagation: after reset, P must never be X when inputs are known.

Decomposition:
- No shared package needed.
  - PW is derived locally.
  - If the team package already holds a MULT_MAX_WIDTH constant (16), reference it for the range check.
- One sub-module is natural: full_adder_cell.
  - Inputs a, b, cin; outputs s, cout; purely combinational.
  - Instantiated in a generate array of (WIDTH-1) x WIDTH cells plus the final ripple row.
  - A half adder is a full_adder_cell with cin tied to 0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, A=3, B=3 -> P=0, out_valid=0 throughout; deassert rst -> the next edge gives P=9, out_valid=1.
- Directed WIDTH=2 sequence, back-to-back in_valid=1:
  - Inputs (2,2), (3,1), (3,3), (1,3), (2,1), (3,2), (1,1), (2,3), (1,2).
  - Expected P one cycle later: 4, 3, 9, 3, 2, 6, 1, 6, 2.
  - out_valid stays 1 throughout.
- Exhaustive WIDTH=2: all 16 (A,B) pairs including zeros -> P = A*B each cycle; (0,3)->0 and (3,0)->0.
- Hold behaviour: apply A=3, B=2 with in_valid=1, then in_valid=0 with A=1, B=1 -> P stays 6 and out_valid drops to 0.
- Mid-stream reset: in_valid=1, A=2, B=3, with rst=1 on the same edge -> P=0, out_valid=0; next edge with rst=0 and A=2, B=3 -> P=6.
- WIDTH=8 corners:
  - 255*255 -> 65025.
  - 255*1 -> 255.
  - 128*2 -> 256.
  - Plus 1000 random pairs checked against a reference model, verifying carry propagation across the full array.
